// File: rtl/corr_accum_dump.sv
// Multi-channel integrate-and-dump correlator accumulator with a held dump register,
// valid/ready handshake, optional saturation, per-channel overflow and overrun detection.
module corr_accum_dump #(
    parameter int unsigned N_CH  = 6,
    parameter int unsigned IN_W  = 20,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned DW_W  = 5,
    parameter bit          SAT   = 1'b1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    accclr,
    input  logic                    en,
    input  logic [N_CH*IN_W-1:0]    datain,
    input  logic                    epoch,
    input  logic [DW_W-1:0]         dwell,
    output logic [N_CH*ACC_W-1:0]   dump_data,
    output logic [N_CH-1:0]         dump_ovf,
    output logic                    dump_valid,
    input  logic                    dump_ready,
    output logic                    overrun
);

    localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

    logic [N_CH*ACC_W-1:0] acc_q, acc_d;
    logic [N_CH*ACC_W-1:0] nxt;
    logic [N_CH-1:0]       ovf_q, ovf_d;
    logic [N_CH-1:0]       edge_ovf;
    logic [DW_W-1:0]       cnt_q, cnt_d;
    logic [N_CH*ACC_W-1:0] dump_data_q, dump_data_d;
    logic [N_CH-1:0]       dump_ovf_q, dump_ovf_d;
    logic                  dump_valid_q, dump_valid_d;
    logic                  overrun_q, overrun_d;

    logic [DW_W:0]         dwell_eff;
    logic [DW_W:0]         cnt_inc;
    logic                  dump_hit;

    // Per-channel add at ACC_W+1 bits; overflow when the two top bits disagree.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [IN_W-1:0]  smp;
        logic [ACC_W-1:0] acc_k;
        logic [ACC_W:0]   sum;
        logic             sum_ovf;
        logic [ACC_W-1:0] fitted;

        assign smp     = datain[k*IN_W +: IN_W];
        assign acc_k   = acc_q[k*ACC_W +: ACC_W];
        assign sum     = {acc_k[ACC_W-1], acc_k}
                       + {{(ACC_W+1-IN_W){smp[IN_W-1]}}, smp};
        assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];

        always_comb begin
            fitted = sum[ACC_W-1:0];
            if (SAT && sum_ovf) begin
                fitted = sum[ACC_W] ? AccMin : AccMax;
            end
        end

        assign nxt[k*ACC_W +: ACC_W] = en ? fitted : acc_k;
        assign edge_ovf[k]           = en & sum_ovf;
    end

    // A dwell of zero behaves as one epoch.
    assign dwell_eff = (dwell == '0) ? (DW_W+1)'(1) : {1'b0, dwell};
    assign cnt_inc   = {1'b0, cnt_q} + (DW_W+1)'(1);
    assign dump_hit  = epoch & ~accclr & (cnt_inc >= dwell_eff);

    always_comb begin
        acc_d        = acc_q;
        ovf_d        = ovf_q;
        cnt_d        = cnt_q;
        dump_data_d  = dump_data_q;
        dump_ovf_d   = dump_ovf_q;
        dump_valid_d = dump_valid_q;
        overrun_d    = overrun_q;

        if (accclr) begin
            // Sample and epoch are dropped; the output handshake still proceeds.
            acc_d     = '0;
            ovf_d     = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
            if (dump_ready) begin
                dump_valid_d = 1'b0;
            end
        end else if (dump_hit) begin
            dump_data_d  = nxt;
            dump_ovf_d   = ovf_q | edge_ovf;
            dump_valid_d = 1'b1;
            if (dump_valid_q && !dump_ready) begin
                overrun_d = 1'b1;
            end
            acc_d = '0;
            ovf_d = '0;
            cnt_d = '0;
        end else begin
            acc_d = nxt;
            ovf_d = ovf_q | edge_ovf;
            if (epoch) begin
                cnt_d = cnt_inc[DW_W-1:0];
            end
            if (dump_ready) begin
                dump_valid_d = 1'b0;
            end
        end
    end

    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            acc_q        <= '0;
            ovf_q        <= '0;
            cnt_q        <= '0;
            dump_data_q  <= '0;
            dump_ovf_q   <= '0;
            dump_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            ovf_q        <= ovf_d;
            cnt_q        <= cnt_d;
            dump_data_q  <= dump_data_d;
            dump_ovf_q   <= dump_ovf_d;
            dump_valid_q <= dump_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dump_data  = dump_data_q;
    assign dump_ovf   = dump_ovf_q;
    assign dump_valid = dump_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_corr_accum_dump.sv
// Randomized and directed bench for corr_accum_dump; a saturating and a wrapping instance
// share stimulus and are compared against an arithmetic reference model.
module tb_corr_accum_dump;

    localparam int N_CH  = 6;
    localparam int IN_W  = 20;
    localparam int ACC_W = 24;
    localparam int DW_W  = 5;

    localparam longint MAXV = (longint'(1) << (ACC_W-1)) - 1;
    localparam longint MINV = -(longint'(1) << (ACC_W-1));
    localparam longint SPAN = longint'(1) << ACC_W;

    logic                  clk = 1'b0;
    logic                  clr;
    logic                  accclr;
    logic                  en;
    logic [N_CH*IN_W-1:0]  datain;
    logic                  epoch;
    logic [DW_W-1:0]       dwell;
    logic                  dump_ready;

    logic [N_CH*ACC_W-1:0] dd_s, dd_w;
    logic [N_CH-1:0]       dov_s, dov_w;
    logic                  dv_s, dv_w, ovr_s, ovr_w;

    corr_accum_dump #(.N_CH(N_CH), .IN_W(IN_W), .ACC_W(ACC_W), .DW_W(DW_W), .SAT(1'b1)) u_dut (
        .clk(clk), .clr(clr), .accclr(accclr), .en(en), .datain(datain), .epoch(epoch),
        .dwell(dwell), .dump_data(dd_s), .dump_ovf(dov_s), .dump_valid(dv_s),
        .dump_ready(dump_ready), .overrun(ovr_s)
    );

    corr_accum_dump #(.N_CH(N_CH), .IN_W(IN_W), .ACC_W(ACC_W), .DW_W(DW_W), .SAT(1'b0)) u_dut_wrap (
        .clk(clk), .clr(clr), .accclr(accclr), .en(en), .datain(datain), .epoch(epoch),
        .dwell(dwell), .dump_data(dd_w), .dump_ovf(dov_w), .dump_valid(dv_w),
        .dump_ready(dump_ready), .overrun(ovr_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: index 0 = saturating, 1 = wrapping.
    longint m_acc  [2][N_CH];
    bit     m_ovf  [2][N_CH];
    int     m_cnt  [2];
    longint m_dd   [2][N_CH];
    bit     m_dovf [2][N_CH];
    bit     m_valid[2];
    bit     m_ovr  [2];

    task automatic check_val(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint sample(input int k);
        logic signed [IN_W-1:0] s;
        s = datain[k*IN_W +: IN_W];
        return longint'(s);
    endfunction

    function automatic longint chan(input logic [N_CH*ACC_W-1:0] v, input int k);
        logic signed [ACC_W-1:0] t;
        t = v[k*ACC_W +: ACC_W];
        return longint'(t);
    endfunction

    function automatic void set_ch(input int k, input longint v);
        logic [IN_W-1:0] t;
        t = IN_W'(v);
        datain[k*IN_W +: IN_W] = t;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < N_CH; k++) begin
                m_acc[i][k] = 0; m_ovf[i][k] = 0; m_dd[i][k] = 0; m_dovf[i][k] = 0;
            end
            m_cnt[i] = 0; m_valid[i] = 0; m_ovr[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            longint nxt[N_CH];
            bit     eov[N_CH];
            int     dw;
            bit     dump;
            if (accclr) begin
                for (int k = 0; k < N_CH; k++) begin
                    m_acc[i][k] = 0; m_ovf[i][k] = 0;
                end
                m_cnt[i] = 0;
                m_ovr[i] = 0;
                if (dump_ready) m_valid[i] = 0;
                continue;
            end
            for (int k = 0; k < N_CH; k++) begin
                longint s;
                s = m_acc[i][k] + (en ? sample(k) : 0);
                eov[k] = en && (s > MAXV || s < MINV);
                if (s > MAXV) s = (i == 0) ? MAXV : s - SPAN;
                else if (s < MINV) s = (i == 0) ? MINV : s + SPAN;
                nxt[k] = s;
            end
            dw   = (dwell == 0) ? 1 : int'(dwell);
            dump = epoch && (m_cnt[i] + 1 >= dw);
            if (dump) begin
                if (m_valid[i] && !dump_ready) m_ovr[i] = 1;
                for (int k = 0; k < N_CH; k++) begin
                    m_dd[i][k]   = nxt[k];
                    m_dovf[i][k] = m_ovf[i][k] | eov[k];
                    m_acc[i][k]  = 0;
                    m_ovf[i][k]  = 0;
                end
                m_valid[i] = 1;
                m_cnt[i]   = 0;
            end else begin
                for (int k = 0; k < N_CH; k++) begin
                    m_acc[i][k] = nxt[k];
                    m_ovf[i][k] = m_ovf[i][k] | eov[k];
                end
                if (epoch) m_cnt[i]++;
                if (dump_ready) m_valid[i] = 0;
            end
        end
    endtask

    task automatic check_inst(input int i, input string nm, input logic [N_CH*ACC_W-1:0] dd,
                              input logic [N_CH-1:0] dov, input logic dv, input logic ovr);
        logic [N_CH-1:0] exp_ovf;
        for (int k = 0; k < N_CH; k++) begin
            exp_ovf[k] = m_dovf[i][k];
            check_val($sformatf("%s.data%0d", nm, k), chan(dd, k), m_dd[i][k]);
        end
        check_val({nm, ".ovf"}, dov, exp_ovf);
        check_val({nm, ".valid"}, dv, m_valid[i]);
        check_val({nm, ".overrun"}, ovr, m_ovr[i]);
    endtask

    task automatic check_outputs();
        check_inst(0, "sat", dd_s, dov_s, dv_s, ovr_s);
        check_inst(1, "wrap", dd_w, dov_w, dv_w, ovr_w);
    endtask

    // Active edge is negedge; model follows the edge, outputs checked 1 unit later.
    task automatic cycle();
        @(negedge clk);
        if (!clr) model_reset();
        else model_step();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        en = 0; epoch = 0; accclr = 0; datain = '0;
    endtask

    initial begin
        logic [N_CH*ACC_W-1:0] held;
        clr = 0; dump_ready = 0; dwell = 1;
        idle();
        model_reset();
        cycle(); cycle();
        @(posedge clk); clr = 1;

        // Basic dump
        for (int k = 0; k < N_CH; k++) set_ch(k, 1000);
        en = 1;
        repeat (5) cycle();
        en = 0; epoch = 1;
        cycle();
        check_val("basic.ch0", chan(dd_s, 0), 5000);
        check_val("basic.valid", dv_s, 1);
        epoch = 0; cycle();
        dump_ready = 1; cycle();
        check_val("basic.cleared", dv_s, 0);
        dump_ready = 0;

        // Multi-epoch dwell, sample on closing epoch edge belongs to that dwell
        idle(); dwell = 3; set_ch(0, 10); en = 1;
        for (int c = 0; c < 30; c++) begin
            epoch = (c == 9 || c == 19 || c == 29);
            cycle();
            if (c == 19) check_val("multi.nodump", dv_s, 0);
        end
        check_val("multi.ch0", chan(dd_s, 0), 300);
        idle(); dump_ready = 1; cycle(); dump_ready = 0;

        // Saturation / wrap on channel 2
        dwell = 1; set_ch(2, 524287); en = 1;
        repeat (20) cycle();
        en = 0; epoch = 1; cycle();
        check_val("sat.ch2", chan(dd_s, 2), 8388607);
        check_val("wrap.ch2", chan(dd_w, 2), -6291476);
        check_val("sat.ovfvec", dov_s, 6'b000100);
        check_val("wrap.ovfvec", dov_w, 6'b000100);
        idle(); dump_ready = 1; set_ch(2, 5); en = 1; cycle();
        en = 0; epoch = 1; cycle();
        check_val("sat.ovfclear", dov_s, 6'b000000);
        idle(); cycle(); dump_ready = 0;

        // Overrun: two dumps with ready low, then second dump accepted on its edge
        for (int k = 0; k < N_CH; k++) set_ch(k, 7);
        en = 1; cycle(); en = 0; epoch = 1; cycle(); epoch = 0;
        for (int k = 0; k < N_CH; k++) set_ch(k, 9);
        en = 1; cycle(); en = 0; epoch = 1; cycle(); epoch = 0;
        check_val("ovr.set", ovr_s, 1);
        check_val("ovr.ch0", chan(dd_s, 0), 9);
        accclr = 1; cycle(); accclr = 0;
        epoch = 1; dump_ready = 1; cycle();
        check_val("ovr.accepted", ovr_s, 0);
        check_val("ovr.valid", dv_s, 1);
        idle(); dump_ready = 0;

        // accclr priority over a closing epoch
        dwell = 1; en = 1; set_ch(1, 3); epoch = 1; cycle(); cycle();
        dwell = 2; epoch = 0; cycle();
        epoch = 1; cycle();
        held = dd_s;
        accclr = 1; epoch = 1; en = 1; cycle();
        check_val("clr.overrun", ovr_s, 0);
        check_val("clr.valid", dv_s, 1);
        check_val("clr.held", chan(dd_s, 1), chan(held, 1));
        accclr = 0; cycle();
        check_val("clr.cntreset", chan(dd_s, 1), chan(held, 1));
        idle();

        // Async reset mid-dwell with a pending dump
        en = 1; set_ch(0, 4); dwell = 1; epoch = 1; cycle(); epoch = 0; cycle();
        @(posedge clk); clr = 0; #1;
        model_reset();
        check_val("rst.valid", dv_s, 0);
        check_val("rst.ch0", chan(dd_s, 0), 0);
        check_outputs();
        cycle();
        @(posedge clk); clr = 1;
        idle(); dwell = 0; set_ch(0, 3); en = 1; epoch = 1; cycle();
        check_val("dw0.ch0", chan(dd_s, 0), 3);
        check_val("dw0.valid", dv_s, 1);
        idle();

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            en         = ($urandom_range(0, 3) != 0);
            epoch      = ($urandom_range(0, 15) == 0);
            accclr     = ($urandom_range(0, 63) == 0);
            dump_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 31) == 0) dwell = DW_W'($urandom_range(0, 4));
            set_ch(0, longint'($urandom_range(300000, 524287)));
            set_ch(1, -longint'($urandom_range(300000, 524288)));
            for (int k = 2; k < N_CH; k++) datain[k*IN_W +: IN_W] = IN_W'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
